// File: rtl/led_out_reg.sv
// LED output register: latches a pattern from a store to the LED address and
// optionally blinks it, with a tick-stretched write-activity indicator.
module led_out_reg #(
  parameter int unsigned TICK_DIV = 50000,
  parameter int unsigned STRETCH  = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ledEnable,
  input  logic [15:0] write_data,
  output logic [9:0]  LEDR,
  output logic [7:0]  wr_count
);

  typedef enum logic [1:0] {
    ST_STATIC    = 2'd0,
    ST_BLINK_ON  = 2'd1,
    ST_BLINK_OFF = 2'd2
  } state_e;

  localparam logic [15:0] PRESC_MAX = 16'(TICK_DIV - 1);
  localparam logic [7:0]  STRETCH_V = 8'(STRETCH);

  state_e      state_q, state_d;
  logic [15:0] presc_q, presc_d;
  logic [7:0]  pattern_q, pattern_d;
  logic        blink_en_q, blink_en_d;
  logic [1:0]  rate_q, rate_d;
  logic [2:0]  blink_cnt_q, blink_cnt_d;
  logic [7:0]  act_q, act_d;
  logic [7:0]  wr_count_q, wr_count_d;
  logic [9:0]  led_q, led_d;

  logic        tick;
  logic [2:0]  blink_limit;
  logic        blink_last;
  logic        unused_wdata;

  assign unused_wdata = ^write_data[15:11];

  assign tick        = (presc_q == PRESC_MAX);
  // Half-period is 2^rate ticks; the counter holds ticks already seen.
  assign blink_limit = 3'((4'd1 << rate_q) - 4'd1);
  assign blink_last  = (blink_cnt_q == blink_limit);

  always_comb begin
    state_d     = state_q;
    presc_d     = presc_q;
    pattern_d   = pattern_q;
    blink_en_d  = blink_en_q;
    rate_d      = rate_q;
    blink_cnt_d = blink_cnt_q;
    act_d       = act_q;
    wr_count_d  = wr_count_q;

    if (ledEnable) begin
      // A write wins over any same-cycle tick: timing restarts from here.
      pattern_d   = write_data[7:0];
      blink_en_d  = write_data[8];
      rate_d      = write_data[10:9];
      presc_d     = 16'd0;
      blink_cnt_d = 3'd0;
      act_d       = STRETCH_V;
      state_d     = write_data[8] ? ST_BLINK_ON : ST_STATIC;
      if (wr_count_q != 8'hFF) begin
        wr_count_d = wr_count_q + 8'd1;
      end
    end else begin
      presc_d = tick ? 16'd0 : presc_q + 16'd1;
      if (tick && (act_q != 8'd0)) begin
        act_d = act_q - 8'd1;
      end
      if (tick && (state_q != ST_STATIC)) begin
        if (blink_last) begin
          blink_cnt_d = 3'd0;
          state_d     = (state_q == ST_BLINK_ON) ? ST_BLINK_OFF : ST_BLINK_ON;
        end else begin
          blink_cnt_d = blink_cnt_q + 3'd1;
        end
      end
    end

    // LEDs are registered from next-state so they track state with no lag.
    led_d = {blink_en_d, (act_d != 8'd0),
             (state_d == ST_BLINK_OFF) ? 8'h00 : pattern_d};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_STATIC;
      presc_q     <= 16'd0;
      pattern_q   <= 8'd0;
      blink_en_q  <= 1'b0;
      rate_q      <= 2'd0;
      blink_cnt_q <= 3'd0;
      act_q       <= 8'd0;
      wr_count_q  <= 8'd0;
      led_q       <= 10'd0;
    end else begin
      state_q     <= state_d;
      presc_q     <= presc_d;
      pattern_q   <= pattern_d;
      blink_en_q  <= blink_en_d;
      rate_q      <= rate_d;
      blink_cnt_q <= blink_cnt_d;
      act_q       <= act_d;
      wr_count_q  <= wr_count_d;
      led_q       <= led_d;
    end
  end

  assign LEDR     = led_q;
  assign wr_count = wr_count_q;

endmodule

// File: tb/tb_led_out_reg.sv
// Scoreboard bench for led_out_reg: a tick-arithmetic model predicts LEDR and
// wr_count after every clock edge; a negedge monitor compares them.
module tb_led_out_reg;

  localparam int TD = 4;
  localparam int ST = 2;

  logic        clk;
  logic        reset;
  logic        ledEnable;
  logic [15:0] write_data;
  logic [9:0]  LEDR;
  logic [7:0]  wr_count;

  int checks = 0;
  int errors = 0;

  led_out_reg #(.TICK_DIV(TD), .STRETCH(ST)) dut (
    .clk        (clk),
    .reset      (reset),
    .ledEnable  (ledEnable),
    .write_data (write_data),
    .LEDR       (LEDR),
    .wr_count   (wr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model state: last write, edges since it, and number of writes.
  logic [17:0] exp_q[$];
  bit          have_w = 0;
  logic [15:0] wdat   = 16'd0;
  int          k      = 0;
  int          nwr    = 0;

  function automatic logic [17:0] predict();
    int          t;
    logic        en;
    logic [7:0]  pat;
    logic        act;
    logic [7:0]  cnt;
    cnt = (nwr > 255) ? 8'hFF : 8'(nwr);
    if (!have_w) return {cnt, 10'h000};
    t   = k / TD;
    en  = wdat[8];
    pat = (en && (((t >> wdat[10:9]) & 1) == 1)) ? 8'h00 : wdat[7:0];
    act = (t < ST);
    return {cnt, en, act, pat};
  endfunction

  always @(posedge clk) begin
    if (!reset) begin
      have_w = 0;
      nwr    = 0;
      k      = 0;
    end else if (ledEnable) begin
      have_w = 1;
      wdat   = write_data;
      k      = 0;
      nwr    = nwr + 1;
      $display("write %0d data=%h", nwr, write_data);
    end else if (have_w) begin
      k = k + 1;
    end
    exp_q.push_back(predict());
  end

  always @(negedge clk) begin
    logic [17:0] e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if ({wr_count, LEDR} !== e) begin
        errors++;
        $display("FAIL out t=%0t LEDR=%h wr_count=%h expected LEDR=%h wr_count=%h",
                 $time, LEDR, wr_count, e[9:0], e[17:10]);
      end
    end
  end

  task automatic chk(input string nm, input logic [17:0] act, input logic [17:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  task automatic cyc(input logic en, input logic [15:0] d);
    @(negedge clk);
    ledEnable  = en;
    write_data = d;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 16'($urandom));
  endtask

  initial begin
    reset      = 1'b0;
    ledEnable  = 1'b1;
    write_data = 16'h01FF;
    #1 chk("por", {wr_count, LEDR}, 18'h0);
    repeat (3) @(negedge clk);
    ledEnable = 1'b0;
    #2 reset = 1'b1;

    // Static write, activity stretch of 2 ticks.
    cyc(1'b1, 16'h00A5); idle(12);
    // Blink rate 1.
    cyc(1'b1, 16'h03F0); idle(40);
    // Write on the tick cycle while in BLINK_OFF.
    cyc(1'b1, 16'h03F0); idle(11);
    cyc(1'b1, 16'h0355); idle(20);
    // Saturation with back-to-back writes.
    for (int i = 0; i < 260; i++) cyc(1'b1, 16'($urandom));
    idle(12);
    chk("sat", {10'h0, wr_count}, 18'h0FF);
    // Blink to static during BLINK_OFF.
    cyc(1'b1, 16'h03F0); idle(10);
    cyc(1'b1, 16'h0011); idle(100);
    // Mid-blink asynchronous reset.
    cyc(1'b1, 16'h03AA); idle(1);
    chk("pre_rst", {8'h0, LEDR}, 18'h3AA);
    @(negedge clk);
    #2 reset = 1'b0;
    #1 chk("async_rst", {wr_count, LEDR}, 18'h0);
    ledEnable = 1'b1;
    repeat (2) @(negedge clk);
    ledEnable = 1'b0;
    #2 reset = 1'b1;
    cyc(1'b1, 16'h0100); idle(6);
    chk("post_rst_cnt", {10'h0, wr_count}, 18'h001);
    // Random traffic, all rates and gaps.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 5) == 0) cyc(1'b1, 16'($urandom));
      else cyc(1'b0, 16'($urandom));
    end
    idle(3);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
